// File: rtl/adder_sequencer_pkg.sv
// Shared definitions for the byte-serial adder sequencer.
// Holds the controller state encoding, the byte width and a small
// signed-overflow helper used when the last byte is processed.
package adder_sequencer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement overflow: operands share a sign that the result does not.
  // Equivalent to (carry into MSB) != (carry out of MSB).
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_sequencer_byte_adder.sv
// 8-bit ripple-carry adder shared by the sequencer: one byte per cycle.
module byte_adder
  import adder_sequencer_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);

  logic [BYTE_W:0] c;

  assign c[0] = cin;

  // One full adder per bit, carry rippling LSB to MSB.
  for (genvar gi = 0; gi < BYTE_W; gi++) begin : g_fa
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = c[BYTE_W];

endmodule

// File: rtl/adder_sequencer.sv
// Byte-serial wide adder: captures two 8*NBYTES-bit operands, then adds
// them one byte per cycle (LSB first) through a single shared byte_adder.
// The result is held in DONE until the consumer accepts it.
// Optional feature: define ADDSEQ_SUB_EN to add the in_sub port, which
// selects a - b computed as a + ~b + 1.
module adder_sequencer
  import adder_sequencer_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] in_a,
  input  logic [BYTE_W*NBYTES-1:0] in_b,
  input  logic                     in_cin,
`ifdef ADDSEQ_SUB_EN
  input  logic                     in_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] out_sum,
  output logic                     out_cout,
  output logic                     out_ovf,
  output logic                     busy
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef logic [NBYTES-1:0][BYTE_W-1:0] word_t;

  state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic       carry_q, carry_d;
  word_t      a_q, a_d;
  word_t      b_q, b_d;
  word_t      sum_q, sum_d;
  logic       cout_q, cout_d;
  logic       ovf_q, ovf_d;
`ifdef ADDSEQ_SUB_EN
  logic       sub_q, sub_d;
`endif

  logic [BYTE_W-1:0] op_a;
  logic [BYTE_W-1:0] op_b;
  logic [BYTE_W-1:0] add_s;
  logic              add_co;
  logic              last_byte;

  // Current byte slice of the captured operands; b is inverted for subtract.
  assign op_a = a_q[idx_q];
`ifdef ADDSEQ_SUB_EN
  assign op_b = sub_q ? ~b_q[idx_q] : b_q[idx_q];
`else
  assign op_b = b_q[idx_q];
`endif

  assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

  byte_adder u_byte_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_co)
  );

  // Next-state and datapath updates; every _d defaults to hold.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef ADDSEQ_SUB_EN
    sub_d   = sub_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = in_a;
          b_d     = in_b;
          idx_d   = '0;
`ifdef ADDSEQ_SUB_EN
          sub_d   = in_sub;
          // Subtraction supplies the +1 of the two's complement via carry-in.
          carry_d = in_sub ? 1'b1 : in_cin;
`else
          carry_d = in_cin;
`endif
        end
      end

      RUN: begin
        sum_d[idx_q] = add_s;
        carry_d      = add_co;
        idx_d        = idx_q + IDX_W'(1);
        if (last_byte) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = add_co;
          ovf_d   = signed_ovf(op_a[BYTE_W-1], op_b[BYTE_W-1], add_s[BYTE_W-1]);
        end
      end

      DONE: begin
        // Return to IDLE only; a new request waits for the next cycle.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ADDSEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef ADDSEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Self-checking bench for adder_sequencer (NBYTES=4): directed corner
// cases, result hold/handshake, mid-operation reset and random operands
// compared against an arithmetic reference model.
module tb_adder_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
`ifdef ADDSEQ_SUB_EN
  logic         in_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int total = 0;
  int bad   = 0;

  adder_sequencer #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef ADDSEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, subtraction as a + ~b + 1.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0]   r;
    logic [W-1:0] bb;
    bb = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    s  = r[W-1:0];
    co = r[W];
    ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
  endtask

  task automatic scramble();
    in_a   = $urandom;
    in_b   = $urandom;
    in_cin = 1'($urandom_range(0, 1));
`ifdef ADDSEQ_SUB_EN
    in_sub = 1'($urandom_range(0, 1));
`endif
  endtask

  // One full transaction: accept, latency, result, hold cycles, handshake.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input int hold);
    logic [W-1:0] es;
    logic         eco, eov;
    model(a, b, cin, sub, es, eco, eov);
    in_a = a; in_b = b; in_cin = cin;
`ifdef ADDSEQ_SUB_EN
    in_sub = sub;
`endif
    in_valid = 1'b1;
    check({tag, ".ready_idle"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    check({tag, ".busy_run"}, {busy, in_ready}, 2'b10);
    for (int n = 1; n < NB; n++) begin
      @(posedge clk); #1;
      check($sformatf("%s.no_valid_c%0d", tag, n), out_valid, 1'b0);
    end
    @(posedge clk); #1;
    check({tag, ".valid_lat"}, out_valid, 1'b1);
    check({tag, ".sum"}, out_sum, es);
    check({tag, ".cout_ovf"}, {out_cout, out_ovf}, {eco, eov});
    for (int h = 0; h < hold; h++) begin
      scramble();
      in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("%s.hold%0d", tag, h),
            {out_valid, in_ready, out_cout, out_ovf, out_sum},
            {1'b1, 1'b0, eco, eov, es});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, ".idle_after"}, {out_valid, busy, in_ready}, 3'b001);
  endtask

  initial begin
    // Reset state while rst_n is low.
    #2;
    check("reset.outs", {out_valid, busy, out_cout, out_ovf, out_sum},
          {1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset.in_ready", in_ready, 1'b1);

    // Directed corner cases.
    run_op("carry_byte", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("wrap_all",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op("sgn_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    // Result hold with inputs toggling and in_valid held high; no bypass.
    run_op("hold5",      32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 5);

    // Reset during the second RUN cycle discards the operation.
    in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst.outs", {out_valid, busy, out_cout, out_ovf, out_sum},
          {1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst.ready", {in_ready, busy}, 2'b10);
    run_op("after_rst", 32'd3, 32'd4, 1'b0, 1'b0, 0);

`ifdef ADDSEQ_SUB_EN
    run_op("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 0);
`endif

    // Random operands against the model.
    for (int i = 0; i < 24; i++) begin
      logic sub;
      sub = 1'b0;
`ifdef ADDSEQ_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      run_op($sformatf("rnd%0d", i), $urandom, $urandom,
             1'($urandom_range(0, 1)), sub, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_sequencer.md
ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the operand width in bytes (8*NBYTES bits); legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, operand request valid.
REQ-005 The block SHALL have port in_ready, output, 1, block accepts a request this cycle.
REQ-006 The block SHALL have ports in_a and in_b, input, 8*NBYTES, operands.
REQ-007 The block SHALL have port in_cin, input, 1, carry-in for addition.
REQ-008 The block SHALL have port in_sub, input, 1, subtract select; present only when ADDSEQ_SUB_EN is defined.
REQ-009 The block SHALL have port out_valid, output, 1, result valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 The block SHALL have port out_sum, output, 8*NBYTES, result.
REQ-012 The block SHALL have ports out_cout and out_ovf, output, 1 each: unsigned carry-out and signed overflow.
REQ-013 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 The block SHALL compute the wide sum using one shared 8-bit ripple adder, one byte per cycle, LSB byte first.
REQ-015 The state machine SHALL have states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 IDLE->RUN on in_valid && in_ready; operands, in_cin (and in_sub) captured into registers; byte index cleared to 0; carry register loaded with in_cin (1 when subtracting).
REQ-017 In RUN, each cycle SHALL add captured byte idx of a and b (b inverted when subtracting) with the carry register, write the sum byte into result byte idx, update carry, increment idx.
REQ-018 RUN->DONE on the cycle processing byte NBYTES-1; out_valid SHALL first be high exactly NBYTES cycles after the accepting edge.
REQ-019 In DONE, out_sum/out_cout/out_ovf SHALL hold stable until out_valid && out_ready, then DONE->IDLE; no new request is accepted in the same cycle (no bypass).
REQ-020 out_cout SHALL equal the final carry; out_ovf SHALL be 1 iff the MSB carry-in differs from the MSB carry-out.
REQ-021 Operand inputs SHALL be ignored outside the accepting cycle; changes during RUN/DONE do not affect the result.
REQ-022 Wrap-around: results are modulo 2^(8*NBYTES); no saturation.

Reset
REQ-023 On rst_n low, at any time including mid-RUN, state SHALL go to IDLE immediately; out_sum=0, out_cout=0, out_ovf=0, out_valid=0, busy=0, idx=0, carry=0; in_ready=1 once rst_n is high; the in-flight operation is discarded.

Configuration
REQ-024 With macro ADDSEQ_SUB_EN defined, in_sub exists and in_sub=1 computes a-b as a+~b+1 (out_cout=1 means no borrow).
REQ-025 Without ADDSEQ_SUB_EN, in_sub is absent and the block only adds a+b+in_cin.

Structure
REQ-026 Package adder_sequencer_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the byte-width constant BYTE_W=8.
REQ-027 The 8-bit adder SHALL be a sub-module named byte_adder (a, b, cin -> s, cout), instantiated once.

Verification
REQ-028 NBYTES=4: a=0x000000FF, b=0x00000001, cin=0 -> out_sum=0x00000100, cout=0, ovf=0, out_valid 4 cycles after accept.
REQ-029 a=0xFFFFFFFF, b=0x00000000, cin=1 -> out_sum=0x00000000, cout=1, ovf=0.
REQ-030 a=0x7FFFFFFF, b=0x00000001, cin=0 -> out_sum=0x80000000, cout=0, ovf=1.
REQ-031 out_ready held low 5 cycles in DONE, inputs toggled -> outputs stable, in_ready=0 throughout; then one-cycle out_ready -> IDLE next cycle.
REQ-032 rst_n pulsed low during second RUN cycle -> all outputs 0 immediately; next request a=3, b=4 -> out_sum=7.
REQ-033 ADDSEQ_SUB_EN defined: a=5, b=7, in_sub=1 -> out_sum=0xFFFFFFFE, cout=0, ovf=0.
